// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_pkg
//  Description : Shared definitions for the word-serial wide adder/subtractor:
//                adder slice width, sequencer state encoding and the word
//                index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wide_add_pkg;

    // Width of the single adder slice that is reused for every word.
    localparam int ADD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index width; a single-word configuration still needs one bit.
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage : wide_add_pkg
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_16bit
//  Description : Combinational 16-bit adder slice with carry in/out and
//                two's-complement signed overflow of the slice.
//  Ports       : a, b      - addends
//                cin       - carry in
//                sum       - a + b + cin, modulo 2^16
//                cout      - carry out of bit 15
//                overflow  - signed overflow of the 16-bit addition
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_16bit
    import wide_add_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [ADD_W:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{ADD_W{1'b0}}, cin};
    assign sum      = w_full[ADD_W-1:0];
    assign cout     = w_full[ADD_W];
    // Overflow: operands share a sign but the result sign differs.
    assign overflow = (a[ADD_W-1] == b[ADD_W-1]) && (w_full[ADD_W-1] != a[ADD_W-1]);

endmodule : adder_16bit
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_seq
//  Description : Multi-cycle WORDS x 16-bit add/subtract sequencer. Drives a
//                single adder_16bit slice one word per cycle, least
//                significant word first, rippling each word's carry into the
//                next. Subtraction is op_a + ~op_b + 1.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready  - request handshake
//                op_a, op_b, cin    - operands and add-mode carry in
//                sub                - 1 selects op_a - op_b (cin ignored)
//                out_valid/out_ready- result handshake
//                sum, cout          - result and MSW carry (sub: 1 = no borrow)
//                overflow           - signed overflow of the full operation
//                busy               - high while RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADD_W*WORDS-1:0] op_a,
    input  logic [ADD_W*WORDS-1:0] op_b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADD_W*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  overflow,
    output logic                  busy
);

    localparam int DW = ADD_W * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(WORDS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_idx;
    logic              r_carry;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [ADD_W-1:0]  r_sum_w [WORDS];
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic [ADD_W-1:0]  w_add_a;
    logic [ADD_W-1:0]  w_add_b;
    logic [ADD_W-1:0]  w_add_sum;
    logic              w_add_cout;
    logic              w_add_ovf;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, index and carry registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            // Subtraction is folded into the adder: invert B, carry in of 1.
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (w_run) begin
            r_carry <= w_add_cout;
            // Wrap on the last word so the index never leaves 0..WORDS-1.
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_add_cout;
                r_ovf  <= w_add_ovf;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Word mux: select the current word of each operand
    // ------------------------------------------------------------------------
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IW'(i)) begin
                w_add_a = r_a[i*ADD_W +: ADD_W];
                w_add_b = r_b[i*ADD_W +: ADD_W];
            end
        end
    end

    adder_16bit u_adder (
        .a        (w_add_a),
        .b        (w_add_b),
        .cin      (r_carry),
        .sum      (w_add_sum),
        .cout     (w_add_cout),
        .overflow (w_add_ovf)
    );

    // ------------------------------------------------------------------------
    // Result demux: each word register captures the slice result on its turn
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < WORDS; g++) begin : g_sum_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_w[g] <= '0;
            end else if (w_run && (r_idx == IW'(g))) begin
                r_sum_w[g] <= w_add_sum;
            end
        end
        assign sum[g*ADD_W +: ADD_W] = r_sum_w[g];
    end

    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule : wide_add_seq
`default_nettype wire

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs WORDS×16-bit add/subtract by driving one 16-bit adder_16bit stage, one word per cycle, LSW first.
- Chains each word's cout into the next word's cin.
- Sits directly upstream of, and wraps, the 16-bit adder.
- Exposes valid/ready handshakes on both sides so wide ALU paths can reuse the single verified 16-bit datapath.

Parameters:
- WORDS, 4, number of 16-bit words per operand; legal range 1..16; operand width is DW = 16*WORDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion acts immediately, release is synchronous to clk.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op_a  in  DW  operand A.
- op_b  in  DW  operand B.
- cin  in  1  carry-in for add mode; ignored when sub=1.
- sub  in  1  1 = compute op_a - op_b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  DW  result, modulo 2^DW.
- cout  out  1  carry out of the MSW. In sub mode, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow of the full DW-bit operation.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0, overflow=0.
  - Word index=0; carry register=0; operand registers=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch op_a, plus op_b (sub=1: latch ~op_b), and set carry = sub ? 1 : cin.
  - Clear idx to 0 and go to RUN.
  - sum/cout/overflow keep their previous values; they are meaningful only while out_valid.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Adder inputs each cycle: a = A[idx], b = B[idx], cin = carry.
  - At each edge: sum[idx] <= adder.sum; carry <= adder.cout; idx <= idx+1.
  - At the edge where idx == WORDS-1: cout <= adder.cout, overflow <= adder.overflow (MSW signed overflow), go to DONE.
- DONE:
  - out_valid=1.
  - sum/cout/overflow are held stable for as long as out_ready=0.
  - On out_valid&&out_ready at an edge: out_valid <= 0, go to IDLE.
- Latency:
  - Accept at edge E; out_valid is high after edge E+WORDS.
  - Minimum initiation interval is WORDS+2 cycles (no accept in DONE; in_ready returns the cycle after the output handshake).
- Boundary conditions:
  - WORDS=1: RUN lasts exactly one cycle.
  - idx width is max(1, $clog2(WORDS)); idx never exceeds WORDS-1.
  - Carry ripples across words, e.g. all-ones + cin=1 propagates through every word.
  - out_ready high while not in DONE: no effect.
  - rst_n asserted in any state: immediate return to reset values, with no glitch-free guarantee on outputs during assertion. The first request after release is accepted normally.
- Sub mode arithmetic:
  - Result is op_a + ~op_b + 1.
  - cout=1 iff op_a >= op_b (unsigned).
  - overflow is the signed overflow of op_a - op_b.

Decomposition:
- Package wide_add_pkg:
  - ADD_W = 16.
  - Enum state_t {IDLE, RUN, DONE}.
  - Function idx_w(WORDS) returning the index width.
- Sub-module: one instance of the existing adder_16bit (ports a, b, cin, sum, cout, overflow).
- No other hierarchy; the remaining logic is the FSM, word mux, and result demux.

Test Plan (WORDS=4):
- Word carry: a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0 -> sum=0x0000_0000_0001_0000, cout=0, overflow=0. out_valid rises exactly 4 edges after accept.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, overflow=1. Separately, a=b=0x8000_0000_0000_0000 -> sum=0, cout=1, overflow=1.
- Subtract: a=0x5, b=0x7, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Separately, a=0x7, b=0x5 -> sum=0x2, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/overflow stable, in_ready=0, busy=1, and a new in_valid is not accepted. Raise out_ready -> out_valid falls and in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 while idx=2 in RUN -> out_valid=0, in_ready=1, sum=0 immediately. After release, a=1, b=2 -> sum=3, cout=0, overflow=0.
